// File: rtl/analog_ctrl_pkg.sv
// analog_ctrl_pkg: shared state encoding and counter types for the analog iteration sequencer
package analog_ctrl_pkg;
    localparam int unsigned ITER_W_DEF    = 16;
    localparam int unsigned TIMEOUT_W_DEF = 16;
    typedef enum logic [2:0] {IDLE, CONFIG, LAUNCH, WAIT_CMPT, WAIT_SPIN} iter_state_e;
    typedef logic [ITER_W_DEF-1:0]    iter_cnt_t;
    typedef logic [TIMEOUT_W_DEF-1:0] timeout_cnt_t;
endpackage

// File: rtl/analog_watchdog.sv
// analog_watchdog: per-iteration down-counter; a zero limit disables expiry entirely
module analog_watchdog #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         i_load,
    input  logic         i_run,
    input  logic [W-1:0] i_limit,
    output logic         o_expired
);
    logic [W-1:0] r_cnt;
    logic         w_disabled;
    assign w_disabled = i_limit == '0;
    assign o_expired  = !w_disabled && r_cnt == '0;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_limit;
        else if (i_run && !w_disabled && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: rtl/analog_iter_ctrl.sv
// analog_iter_ctrl: sequences configure / launch / compute / spin-drain iterations on the analog macro
module analog_iter_ctrl
    import analog_ctrl_pkg::*;
#(
    parameter int unsigned SYNCHRONIZER_PIPEDEPTH = 3,
    parameter int unsigned ITER_W                 = ITER_W_DEF,
    parameter int unsigned TIMEOUT_W              = TIMEOUT_W_DEF,
    localparam int unsigned PIPE_W = SYNCHRONIZER_PIPEDEPTH > 1 ? $clog2(SYNCHRONIZER_PIPEDEPTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [ITER_W-1:0]    num_iter_i,
    input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
    input  logic [PIPE_W-1:0]    synchronizer_pipe_num_i,
    output logic                 tx_configure_enable_o,
    output logic [PIPE_W-1:0]    synchronizer_pipe_num_o,
    output logic                 macro_start_o,
    input  logic                 analog_macro_cmpt_finish_i,
    input  logic                 spin_handshake_i,
    input  logic                 analog_tx_idle_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic                 spurious_finish_o,
    output logic [ITER_W-1:0]    iter_cnt_o
);
    iter_state_e          r_state;
    logic [ITER_W-1:0]    r_num_iter, r_iter;
    logic [TIMEOUT_W-1:0] r_timeout_cfg;
    logic [PIPE_W-1:0]    r_pipe;
    logic                 r_done, r_timeout, r_spur;
    logic                 w_kill, w_expired;
    logic [ITER_W-1:0]    w_iter_inc;
    assign w_kill     = r_state != IDLE && (abort_i || !en_i);
    assign w_iter_inc = &r_iter ? r_iter : r_iter + 1'b1;
    // strobes are gated so an abort cycle never emits a launch or configure
    assign tx_configure_enable_o   = r_state == CONFIG && analog_tx_idle_i && !w_kill;
    assign macro_start_o           = r_state == LAUNCH && !w_kill;
    assign busy_o                  = r_state != IDLE;
    assign done_o                  = r_done;
    assign timeout_o               = r_timeout;
    assign spurious_finish_o       = r_spur;
    assign iter_cnt_o              = r_iter;
    assign synchronizer_pipe_num_o = r_pipe;
    analog_watchdog #(.W(TIMEOUT_W)) u_wdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_load    (r_state == LAUNCH),
        .i_run     (r_state == WAIT_CMPT),
        .i_limit   (r_timeout_cfg),
        .o_expired (w_expired)
    );
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_num_iter    <= '0;
            r_iter        <= '0;
            r_timeout_cfg <= '0;
            r_pipe        <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_spur        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_kill)
                r_state <= IDLE;
            else
                case (r_state)
                    IDLE: if (start_i && en_i) begin
                        r_num_iter    <= num_iter_i;
                        r_timeout_cfg <= timeout_cycles_i;
                        r_pipe        <= synchronizer_pipe_num_i;
                        r_iter        <= '0;
                        r_timeout     <= 1'b0;
                        r_spur        <= 1'b0;
                        if (num_iter_i == '0)
                            r_done <= 1'b1;
                        else
                            r_state <= CONFIG;
                    end
                    CONFIG: if (analog_tx_idle_i) r_state <= LAUNCH;
                    LAUNCH: r_state <= WAIT_CMPT;
                    WAIT_CMPT: if (analog_macro_cmpt_finish_i)
                        r_state <= WAIT_SPIN;
                    else if (w_expired) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= IDLE;
                    end
                    WAIT_SPIN: if (spin_handshake_i) begin
                        r_iter  <= w_iter_inc;
                        r_done  <= w_iter_inc == r_num_iter;
                        r_state <= w_iter_inc == r_num_iter ? IDLE : LAUNCH;
                    end
                    default: r_state <= IDLE;
                endcase
            if (analog_macro_cmpt_finish_i && r_state != WAIT_CMPT)
                r_spur <= 1'b1;
        end
    end
endmodule

// File: tb/tb_analog_iter_ctrl.sv
// tb_analog_iter_ctrl: scenario table, hand-written corner sequences and randomized runs against a run-level model
module tb_analog_iter_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b1, start = 1'b0, abort_s = 1'b0;
    logic [15:0] num_iter = '0, tmo = '0;
    logic [1:0]  pipe_in = '0, pipe_out;
    logic        cfg, ms, fin = 1'b0, hs = 1'b0, tx_idle = 1'b0;
    logic        busy, done, to, spur;
    logic [15:0] iter;
    int          n_chk = 0, n_err = 0;
    int          fd[8], sd[8];

    typedef struct {
        int n; int t; int q; int pipe; int f; int s; bit hold;
        int e_iter; bit e_to; int e_st;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    analog_iter_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .start_i(start), .abort_i(abort_s),
        .num_iter_i(num_iter), .timeout_cycles_i(tmo), .synchronizer_pipe_num_i(pipe_in),
        .tx_configure_enable_o(cfg), .synchronizer_pipe_num_o(pipe_out), .macro_start_o(ms),
        .analog_macro_cmpt_finish_i(fin), .spin_handshake_i(hs), .analog_tx_idle_i(tx_idle),
        .busy_o(busy), .done_o(done), .timeout_o(to), .spurious_finish_o(spur), .iter_cnt_o(iter)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // run-level expectation: the first iteration whose finish comes later than T+1 WAIT_CMPT cycles times out
    function automatic void model(input int n, input int t, output int e_iter, output bit e_to, output int e_st);
        e_iter = n;
        e_to   = 1'b0;
        for (int i = 0; i < n; i++)
            if (t != 0 && fd[i] > t + 1) begin
                e_iter = i;
                e_to   = 1'b1;
                break;
            end
        e_st = e_to ? e_iter + 1 : n;
    endfunction

    task automatic run(input int n, input int t, input int q, input int pipe, input bit hold,
                       input int e_iter, input bit e_to, input int e_st);
        int nst = 0, ncfg = 0, it = 0, fin_at = -1, hs_at = -1, exp_st = q + 2, exp_done = -1;
        bit seen = 1'b0;
        num_iter = 16'(n);
        tmo      = 16'(t);
        pipe_in  = 2'(pipe);
        for (int c = 0; c < 600 && !seen; c++) begin
            start = (c == 0) || hold;
            if (c == 1) begin
                num_iter = 16'(n + 5);
                tmo      = 16'(t + 7);
                pipe_in  = 2'(~pipe);
            end
            tx_idle = c > q;
            fin     = c == fin_at;
            hs      = c == hs_at;
            @(negedge clk);
            if (cfg) begin
                ncfg++;
                chk("cfg_cycle", c, q + 1);
            end
            if (ms) begin
                nst++;
                chk("start_cycle", c, exp_st);
                if (t != 0 && fd[it] > t + 1) exp_done = c + t + 2;
                else fin_at = c + fd[it];
            end
            if (fin) hs_at = c + 1 + sd[it];
            if (hs) begin
                it++;
                if (it == n) exp_done = c + 1;
                else exp_st = c + 1;
            end
            if (done) begin
                seen = 1'b1;
                chk("done_cycle", c, exp_done);
                chk("busy_at_done", busy, 0);
                chk("iter_cnt", iter, e_iter);
                chk("timeout_flag", to, e_to);
                chk("spurious_flag", spur, 0);
                chk("pipe_latched", pipe_out, pipe);
                chk("start_count", nst, e_st);
                chk("cfg_count", ncfg, 1);
            end
            tick();
        end
        if (!seen) chk("run_done_seen", 0, 1);
        start = 1'b0; fin = 1'b0; hs = 1'b0; abort_s = hold;
        @(negedge clk);
        chk("single_done", done, 0);
        chk("no_cfg_on_abort", cfg, 0);
        tick();
        abort_s = 1'b0;
        tick();
    endtask

    initial begin
        int e_iter, e_st, n, t;
        bit e_to;
        tbl[0] = '{3, 0, 0, 1, 5, 0, 1'b0, 3, 1'b0, 3};
        tbl[1] = '{2, 4, 0, 1, 20, 0, 1'b0, 0, 1'b1, 1};
        tbl[2] = '{1, 4, 0, 3, 5, 1, 1'b0, 1, 1'b0, 1};
        tbl[3] = '{2, 0, 6, 2, 3, 2, 1'b0, 2, 1'b0, 2};
        tbl[4] = '{4, 3, 1, 3, 4, 1, 1'b1, 4, 1'b0, 4};
        tbl[5] = '{2, 2, 2, 0, 4, 0, 1'b0, 0, 1'b1, 1};

        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", to, 0);
        chk("rst_spur", spur, 0);
        chk("rst_iter", iter, 0);
        chk("rst_pipe", pipe_out, 0);
        chk("rst_strobes", {cfg, ms}, 0);
        tick();

        // zero-iteration run: done next cycle, never busy or launching
        num_iter = 0; tmo = 0; pipe_in = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_ms", ms, 0);
        tick();
        @(negedge clk);
        chk("zero_done_pulse", done, 0);
        tick();

        // abort in the 2nd WAIT_SPIN with a coincident handshake, then a finish while idle
        num_iter = 4; tx_idle = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        chk("ab_ms1", ms, 1);
        tick();
        fin = 1'b1; tick();
        fin = 1'b0; hs = 1'b1; tick();
        hs = 1'b0;
        @(negedge clk);
        chk("ab_ms2", ms, 1);
        tick();
        fin = 1'b1; tick();
        fin = 1'b0; hs = 1'b1; abort_s = 1'b1;
        @(negedge clk);
        chk("ab_busy_before", busy, 1);
        tick();
        hs = 1'b0; abort_s = 1'b0;
        @(negedge clk);
        chk("ab_busy_after", busy, 0);
        chk("ab_no_done", done, 0);
        chk("ab_iter", iter, 1);
        tick();
        fin = 1'b1; tick();
        fin = 1'b0;
        @(negedge clk);
        chk("spur_set", spur, 1);
        chk("spur_iter_hold", iter, 1);
        tick();

        // abort during CONFIG with TX idle suppresses the configure strobe
        num_iter = 1; start = 1'b1; tick();
        start = 1'b0; abort_s = 1'b1;
        @(negedge clk);
        chk("cfg_abort_strobe", cfg, 0);
        tick();
        abort_s = 1'b0;
        @(negedge clk);
        chk("cfg_abort_idle", busy, 0);
        tick();

        // dropping enable in LAUNCH suppresses the launch strobe
        start = 1'b1; tick();
        start = 1'b0; tick();
        en = 1'b0;
        @(negedge clk);
        chk("en_low_ms", ms, 0);
        tick();
        en = 1'b1;
        @(negedge clk);
        chk("en_low_idle", busy, 0);
        tick();

        // asynchronous reset in the middle of LAUNCH
        num_iter = 2; pipe_in = 2'd2; start = 1'b1; tick();
        start = 1'b0; tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ms", ms, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pipe", pipe_out, 0);
        chk("arst_spur", spur, 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 8; k++) begin
                fd[k] = tbl[i].f;
                sd[k] = tbl[i].s;
            end
            run(tbl[i].n, tbl[i].t, tbl[i].q, tbl[i].pipe, tbl[i].hold, tbl[i].e_iter, tbl[i].e_to, tbl[i].e_st);
        end

        for (int r = 0; r < 20; r++) begin
            n = int'($urandom_range(1, 5));
            t = $urandom_range(0, 2) == 0 ? 0 : int'($urandom_range(1, 6));
            for (int k = 0; k < 8; k++) begin
                fd[k] = int'($urandom_range(1, 9));
                sd[k] = int'($urandom_range(0, 3));
            end
            model(n, t, e_iter, e_to, e_st);
            run(n, t, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), e_iter, e_to, e_st);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
